matmul_tile_sequencer: RTL

- Sequential controller wrapped around the combinational matrix_multiplication_accumulation datapath.
- Computes D = C + sum over kt of A_kt x B_kt. It streams K-dimension operand tiles through the datapath and feeds the previous result back as C on each step.
- Holds the M x N accumulator in registers and presents the finished tile on a valid/ready output.
- Sits between the operand streamer and the writeback path of the GEMM core.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matrix_multiplication_accumulation.sv | 74 +++++++
 rtl/matmul_tile_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the matmul tile sequencer and its MAC datapath.
package matmul_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} seq_state_e;

    localparam int unsigned DEF_M = 2;
    localparam int unsigned DEF_N = 2;
    localparam int unsigned DEF_K = 2;
    localparam int unsigned DEF_P = 8;

    // Accumulator lanes are four operand widths wide.
    function automatic int unsigned acc_width(input int unsigned p);
        return 4 * p;
    endfunction

    localparam int unsigned ACC_W = acc_width(DEF_P);

    typedef logic signed [DEF_M-1:0][DEF_K-1:0][DEF_P-1:0] a_tile_t;
    typedef logic signed [DEF_K-1:0][DEF_N-1:0][DEF_P-1:0] b_tile_t;
    typedef logic signed [DEF_M-1:0][DEF_N-1:0][ACC_W-1:0] acc_tile_t;

endpackage

// File: rtl/matrix_multiplication_accumulation.sv
// Combinational D = C + A x B over one operand tile, with optional halved-precision lanes.
module matrix_multiplication_accumulation
    import matmul_pkg::*;
#(
    parameter int unsigned M            = DEF_M,
    parameter int unsigned N            = DEF_N,
    parameter int unsigned K            = DEF_K,
    parameter int unsigned P            = DEF_P,
    parameter int unsigned TREE         = 0,
    parameter int unsigned CONFIGURABLE = 0
) (
    input  logic [M-1:0][K-1:0][P-1:0]              a_i,
    input  logic [K-1:0][N-1:0][P-1:0]              b_i,
    input  logic [M-1:0][N-1:0][acc_width(P)-1:0]   c_i,
    input  logic                                    halved_i,
    output logic [M-1:0][N-1:0][acc_width(P)-1:0]   d_c
);

    localparam int unsigned AW = acc_width(P);
    localparam int unsigned HP = P / 2;
    localparam int unsigned L  = 2 * K;

    logic hv;

    assign hv = (CONFIGURABLE != 0) && halved_i;

    function automatic logic [AW-1:0] sx_full(input logic [P-1:0] v);
        return AW'($signed(v));
    endfunction

    function automatic logic [AW-1:0] sx_half(input logic [HP-1:0] v);
        return AW'($signed(v));
    endfunction

    function automatic logic [K-1:0][P-1:0] column(input logic [K-1:0][N-1:0][P-1:0] bm,
                                                   input int unsigned col);
        logic [K-1:0][P-1:0] r;
        r = '0;
        for (int unsigned kk = 0; kk < K; kk++) r[kk] = bm[kk][col];
        return r;
    endfunction

    // In halved mode each P-bit lane carries two independent P/2-bit signed elements.
    function automatic logic [AW-1:0] dot(input logic [K-1:0][P-1:0] arow,
                                          input logic [K-1:0][P-1:0] bcol,
                                          input logic                half);
        logic [L-1:0][AW-1:0] t;
        t = '0;
        for (int unsigned kk = 0; kk < K; kk++) begin
            if (half) begin
                t[2*kk]   = sx_half(arow[kk][HP-1:0]) * sx_half(bcol[kk][HP-1:0]);
                t[2*kk+1] = sx_half(arow[kk][P-1:HP]) * sx_half(bcol[kk][P-1:HP]);
            end else begin
                t[2*kk]   = sx_full(arow[kk]) * sx_full(bcol[kk]);
            end
        end
        if (TREE != 0) begin
            for (int unsigned s = 1; s < L; s = s * 2)
                for (int unsigned x = 0; x + s < L; x = x + 2 * s)
                    t[x] = t[x] + t[x+s];
        end else begin
            for (int unsigned x = 1; x < L; x++) t[0] = t[0] + t[x];
        end
        return t[0];
    endfunction

    always_comb begin
        d_c = '0;
        for (int unsigned i = 0; i < M; i++)
            for (int unsigned j = 0; j < N; j++)
                d_c[i][j] = c_i[i][j] + dot(a_i[i], column(b_i, j), hv);
    end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Streams K operand tiles through the MAC datapath, accumulating into a registered M x N tile.
module matmul_tile_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned M            = DEF_M,
    parameter int unsigned N            = DEF_N,
    parameter int unsigned K            = DEF_K,
    parameter int unsigned P            = DEF_P,
    parameter int unsigned TREE         = 0,
    parameter int unsigned CONFIGURABLE = 0,
    parameter int unsigned KTW          = 8
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    cfg_valid_i,
    output logic                                    cfg_ready_o,
    input  logic [KTW-1:0]                          cfg_k_tiles_i,
    input  logic                                    cfg_acc_init_i,
    input  logic                                    cfg_halved_i,
    input  logic [M-1:0][N-1:0][acc_width(P)-1:0]   c_i,
    input  logic                                    ab_valid_i,
    output logic                                    ab_ready_o,
    input  logic [M-1:0][K-1:0][P-1:0]              a_i,
    input  logic [K-1:0][N-1:0][P-1:0]              b_i,
    output logic                                    d_valid_o,
    input  logic                                    d_ready_i,
    output logic [M-1:0][N-1:0][acc_width(P)-1:0]   d_o,
    output logic                                    busy_o
);

    localparam int unsigned AW = acc_width(P);

    seq_state_e                  state_q;
    logic [KTW-1:0]              k_cnt_q;
    logic [KTW-1:0]              k_tiles_q;
    logic                        halved_q;
    logic [M-1:0][N-1:0][AW-1:0] acc_q;
    logic [M-1:0][N-1:0][AW-1:0] mac_d_c;

    matrix_multiplication_accumulation #(
        .M            (M),
        .N            (N),
        .K            (K),
        .P            (P),
        .TREE         (TREE),
        .CONFIGURABLE (CONFIGURABLE)
    ) u_mac (
        .a_i      (a_i),
        .b_i      (b_i),
        .c_i      (acc_q),
        .halved_i (halved_q),
        .d_c      (mac_d_c)
    );

    assign d_o = acc_q;

    // Handshake outputs are registered alongside the state they describe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            k_cnt_q     <= '0;
            k_tiles_q   <= '0;
            halved_q    <= 1'b0;
            acc_q       <= '0;
            cfg_ready_o <= 1'b1;
            ab_ready_o  <= 1'b0;
            d_valid_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        k_tiles_q   <= cfg_k_tiles_i;
                        halved_q    <= (CONFIGURABLE != 0) && cfg_halved_i;
                        acc_q       <= cfg_acc_init_i ? c_i : '0;
                        k_cnt_q     <= '0;
                        cfg_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (cfg_k_tiles_i != '0) begin
                            state_q    <= ACCUM;
                            ab_ready_o <= 1'b1;
                        end else begin
                            state_q   <= DRAIN;
                            d_valid_o <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (ab_valid_i) begin
                        acc_q <= mac_d_c;
                        if (k_cnt_q == k_tiles_q - KTW'(1)) begin
                            k_cnt_q    <= '0;
                            state_q    <= DRAIN;
                            ab_ready_o <= 1'b0;
                            d_valid_o  <= 1'b1;
                        end else begin
                            k_cnt_q <= k_cnt_q + KTW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (d_ready_i) begin
                        state_q     <= IDLE;
                        d_valid_o   <= 1'b0;
                        cfg_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cfg_ready_o <= 1'b1;
                    ab_ready_o  <= 1'b0;
                    d_valid_o   <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
